// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry FIFO of fetched bundles between fetch and decode.
// Optional macro FETCHQ_STALL_STATS_EN adds the Full_Stall_Cycles counter.
module fetch_queue #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              FLUSH,
    input  logic              Enq_Valid,
    output logic              Enq_Ready,
    input  logic [DATA_W-1:0] Instr_IN,
    input  logic [DATA_W-1:0] Instr_PC_IN,
    input  logic [DATA_W-1:0] Instr_PC_Plus4_IN,
    input  logic              Branch_prediction_IN,
    input  logic              STALL,
    output logic              Deq_Valid,
    output logic [DATA_W-1:0] Instr_OUT,
    output logic [DATA_W-1:0] Instr_PC_OUT,
    output logic [DATA_W-1:0] Instr_PC_Plus4_OUT,
    output logic              Branch_prediction_OUT,
`ifdef FETCHQ_STALL_STATS_EN
    output logic [31:0]       Full_Stall_Cycles,
`endif
    output logic [PTR_W:0]    Count
);

    logic [DATA_W-1:0] instr_q [DEPTH];
    logic [DATA_W-1:0] pc_q    [DEPTH];
    logic [DATA_W-1:0] pc4_q   [DEPTH];
    logic              bp_q    [DEPTH];
    logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              enq, deq;

    assign Enq_Ready = count_q != (PTR_W+1)'(DEPTH);
    assign Deq_Valid = count_q != '0;
    assign enq       = Enq_Valid && Enq_Ready;
    assign deq       = Deq_Valid && !STALL;
    assign Count     = count_q;

    assign Instr_OUT             = Deq_Valid ? instr_q[rptr_q] : '0;
    assign Instr_PC_OUT          = Deq_Valid ? pc_q[rptr_q]    : '0;
    assign Instr_PC_Plus4_OUT    = Deq_Valid ? pc4_q[rptr_q]   : '0;
    assign Branch_prediction_OUT = Deq_Valid ? bp_q[rptr_q]    : 1'b0;

    // Next pointers and occupancy; flush overrides both handshakes
    always_comb begin
        wptr_d  = FLUSH ? '0 : enq ? wptr_q + PTR_W'(1) : wptr_q;
        rptr_d  = FLUSH ? '0 : deq ? rptr_q + PTR_W'(1) : rptr_q;
        count_d = FLUSH         ? '0 :
                  (enq && !deq) ? count_q + (PTR_W+1)'(1) :
                  (deq && !enq) ? count_q - (PTR_W+1)'(1) : count_q;
    end

    // Pointer and occupancy registers
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Entry storage; a flushed cycle drops the write, stale data stays masked
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
                pc4_q[i]   <= '0;
                bp_q[i]    <= 1'b0;
            end
        end else if (enq && !FLUSH) begin
            instr_q[wptr_q] <= Instr_IN;
            pc_q[wptr_q]    <= Instr_PC_IN;
            pc4_q[wptr_q]   <= Instr_PC_Plus4_IN;
            bp_q[wptr_q]    <= Branch_prediction_IN;
        end
    end

`ifdef FETCHQ_STALL_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    assign Full_Stall_Cycles = stall_cnt_q;

    // Saturating count of cycles where fetch was held off by a full queue
    always_comb begin
        stall_cnt_d = FLUSH ? '0 :
                      (Enq_Valid && !Enq_Ready && stall_cnt_q != '1) ? stall_cnt_q + 32'd1 : stall_cnt_q;
    end

    // Stall statistics register
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) stall_cnt_q <= '0;
        else       stall_cnt_q <= stall_cnt_d;
    end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed and randomized checks of fetch_queue against a queue model.
module tb_fetch_queue;
    localparam int DEPTH = 4;

    logic        CLK = 0, RESET = 0, FLUSH = 0, Enq_Valid = 0, STALL = 0, Branch_prediction_IN = 0;
    logic [31:0] Instr_IN = 0, Instr_PC_IN = 0, Instr_PC_Plus4_IN = 0;
    logic        Enq_Ready, Deq_Valid, Branch_prediction_OUT;
    logic [31:0] Instr_OUT, Instr_PC_OUT, Instr_PC_Plus4_OUT;
    logic [2:0]  Count;
`ifdef FETCHQ_STALL_STATS_EN
    logic [31:0] Full_Stall_Cycles;
`endif

    int pass_cnt = 0, total = 0;
    logic [96:0] mq[$];
    logic [31:0] mstats = 0;

    fetch_queue #(.DATA_W(32), .DEPTH(DEPTH), .PTR_W(2)) dut (
        .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH), .Enq_Valid(Enq_Valid), .Enq_Ready(Enq_Ready),
        .Instr_IN(Instr_IN), .Instr_PC_IN(Instr_PC_IN), .Instr_PC_Plus4_IN(Instr_PC_Plus4_IN),
        .Branch_prediction_IN(Branch_prediction_IN), .STALL(STALL), .Deq_Valid(Deq_Valid),
        .Instr_OUT(Instr_OUT), .Instr_PC_OUT(Instr_PC_OUT), .Instr_PC_Plus4_OUT(Instr_PC_Plus4_OUT),
        .Branch_prediction_OUT(Branch_prediction_OUT),
`ifdef FETCHQ_STALL_STATS_EN
        .Full_Stall_Cycles(Full_Stall_Cycles),
`endif
        .Count(Count)
    );

    always #5 CLK = ~CLK;

    function automatic logic [101:0] obs();
        return {Enq_Ready, Deq_Valid, Count, Branch_prediction_OUT, Instr_OUT, Instr_PC_OUT, Instr_PC_Plus4_OUT};
    endfunction

    function automatic logic [101:0] expv();
        int n = mq.size();
        return {n != DEPTH, n != 0, 3'(n), (n != 0) ? mq[0] : 97'd0};
    endfunction

    task automatic drive(input logic ev, input logic st, input logic [31:0] pc);
        Enq_Valid = ev;
        STALL = st;
        Instr_PC_IN = pc;
        Instr_PC_Plus4_IN = pc + 32'd4;
        Instr_IN = $urandom;
        Branch_prediction_IN = 1'($urandom);
    endtask

    // Advance one clock edge, updating the model from the queue rules first
    task automatic step();
        int n = mq.size();
        if (FLUSH) begin
            mq.delete();
            mstats = 0;
        end else begin
            if (Enq_Valid && n == DEPTH && mstats != 32'hFFFFFFFF) mstats++;
            if (n != 0 && !STALL) void'(mq.pop_front());
            if (Enq_Valid && n != DEPTH) mq.push_back({Branch_prediction_IN, Instr_IN, Instr_PC_IN, Instr_PC_Plus4_IN});
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1;
        mq.delete();
        mstats = 0;
        #2;
        RESET = 0;
        Enq_Valid = 0; STALL = 0; FLUSH = 0;
    endtask

    task automatic test_reset();
        @(posedge CLK); #1;
        do_reset();
        total++;
        if (obs() !== {1'b1, 1'b0, 3'd0, 97'd0}) $display("FAIL reset act=%h exp=%h", obs(), {1'b1, 1'b0, 3'd0, 97'd0});
        else pass_cnt++;
    endtask

    task automatic test_single();
        Enq_Valid = 1; STALL = 1;
        Instr_IN = 32'h8C010004; Instr_PC_IN = 32'h00400000; Instr_PC_Plus4_IN = 32'h00400004; Branch_prediction_IN = 1;
        step();
        total++;
        if (obs() !== {1'b1, 1'b1, 3'd1, 1'b1, 32'h8C010004, 32'h00400000, 32'h00400004})
            $display("FAIL single_enq act=%h exp=%h", obs(), {1'b1, 1'b1, 3'd1, 1'b1, 32'h8C010004, 32'h00400000, 32'h00400004});
        else pass_cnt++;
        Enq_Valid = 0; STALL = 0;
        step();
        total++;
        if (obs() !== {1'b1, 1'b0, 3'd0, 97'd0}) $display("FAIL single_deq act=%h exp=%h", obs(), {1'b1, 1'b0, 3'd0, 97'd0});
        else pass_cnt++;
    endtask

    task automatic test_fill_stall();
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 32'h100 + 32'(4 * i));
            step();
            total++;
            if (Count !== 3'(i < 4 ? i + 1 : 4) || Enq_Ready !== (i < 3))
                $display("FAIL fill_%0d count=%0d ready=%b exp_count=%0d", i, Count, Enq_Ready, (i < 4 ? i + 1 : 4));
            else pass_cnt++;
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (Instr_PC_OUT !== 32'h100 + 32'(4 * i) || obs() !== expv())
                $display("FAIL drain_%0d pc=%h exp=%h", i, Instr_PC_OUT, 32'h100 + 32'(4 * i));
            else pass_cnt++;
            drive(0, 0, 0);
            step();
        end
        total++;
        if (obs() !== {1'b1, 1'b0, 3'd0, 97'd0}) $display("FAIL drain_empty act=%h exp=%h", obs(), {1'b1, 1'b0, 3'd0, 97'd0});
        else pass_cnt++;
    endtask

    task automatic test_full_deq();
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 32'h300 + 32'(4 * i));
            step();
        end
        drive(1, 0, 32'h200);
        step();
        total++;
        if (Count !== 3'd3 || Enq_Ready !== 1'b1 || Instr_PC_OUT !== 32'h304)
            $display("FAIL full_deq count=%0d ready=%b pc=%h exp 3 1 00000304", Count, Enq_Ready, Instr_PC_OUT);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0);
            step();
        end
        total++;
        if (Deq_Valid !== 1'b0 || Count !== 3'd0) $display("FAIL full_deq_drop valid=%b count=%0d exp 0 0", Deq_Valid, Count);
        else pass_cnt++;
    endtask

    task automatic test_streaming();
        drive(1, 0, 32'h1000);
        step();
        for (int k = 0; k < 10; k++) begin
            total++;
            if (Count !== 3'd1 || Instr_PC_OUT !== 32'h1000 + 32'(4 * k) || obs() !== expv())
                $display("FAIL stream_%0d count=%0d pc=%h exp_pc=%h", k, Count, Instr_PC_OUT, 32'h1000 + 32'(4 * k));
            else pass_cnt++;
            drive(1, 0, 32'h1004 + 32'(4 * k));
            step();
        end
        drive(0, 0, 0);
        step();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 7; i++) begin
            drive(1, 1, 32'h500 + 32'(4 * i));
            step();
        end
`ifdef FETCHQ_STALL_STATS_EN
        total++;
        if (Full_Stall_Cycles !== 32'd3) $display("FAIL stall_stats act=%0d exp=3", Full_Stall_Cycles);
        else pass_cnt++;
`endif
        drive(0, 0, 0);
        step();
        total++;
        if (Count !== 3'd3) $display("FAIL pre_flush count=%0d exp=3", Count);
        else pass_cnt++;
        drive(1, 0, 32'h600);
        FLUSH = 1;
        step();
        FLUSH = 0;
        total++;
        if (obs() !== {1'b1, 1'b0, 3'd0, 97'd0}) $display("FAIL flush act=%h exp=%h", obs(), {1'b1, 1'b0, 3'd0, 97'd0});
        else pass_cnt++;
`ifdef FETCHQ_STALL_STATS_EN
        total++;
        if (Full_Stall_Cycles !== 32'd0) $display("FAIL flush_stats act=%0d exp=0", Full_Stall_Cycles);
        else pass_cnt++;
`endif
        drive(1, 1, 32'h700);
        step();
        drive(0, 1, 0);
        FLUSH = 1;
        step();
        FLUSH = 0;
        total++;
        if (Count !== 3'd0 || Deq_Valid !== 1'b0) $display("FAIL flush_stall count=%0d valid=%b exp 0 0", Count, Deq_Valid);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        drive(1, 1, 32'h800);
        step();
        drive(1, 1, 32'h804);
        step();
        drive(0, 0, 0);
        #3;
        RESET = 1;
        mq.delete();
        mstats = 0;
        #1;
        total++;
        if (Count !== 3'd0 || Deq_Valid !== 1'b0 || Enq_Ready !== 1'b1 || Instr_PC_OUT !== 32'd0)
            $display("FAIL async_reset count=%0d valid=%b ready=%b exp 0 0 1", Count, Deq_Valid, Enq_Ready);
        else pass_cnt++;
        #1;
        RESET = 0;
        @(posedge CLK); #1;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0), $urandom);
            FLUSH = ($urandom_range(0, 40) == 0);
            step();
            FLUSH = 0;
            total++;
            if (obs() !== expv()) $display("FAIL random_%0d act=%h exp=%h", c, obs(), expv());
            else pass_cnt++;
`ifdef FETCHQ_STALL_STATS_EN
            total++;
            if (Full_Stall_Cycles !== mstats) $display("FAIL random_stats_%0d act=%0d exp=%0d", c, Full_Stall_Cycles, mstats);
            else pass_cnt++;
`endif
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_stall();
        test_full_deq();
        test_streaming();
        test_flush();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised, multi-entry instruction buffer between the fetch stage and decode; the next generation of the single-entry IF/ID pipeline register.
- Decouples fetch from decode stalls by holding up to DEPTH fetched instruction bundles (instruction, PC, PC+4, branch prediction bit).
- Adds a valid/ready handshake toward fetch, a valid/stall handshake toward decode, occupancy reporting and full flush.

Parameters:
- DATA_W, 32, width of instruction, PC and PC+4 fields.
- DEPTH, 4, number of entries; power of two, minimum 2.
- PTR_W, 2, pointer width; must equal log2(DEPTH).

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RESET  input  1  asynchronous, active-high reset.
- FLUSH  input  1  synchronous flush; empties queue at next rising edge.
- Enq_Valid  input  1  fetch presents a bundle this cycle.
- Enq_Ready  output  1  queue can accept a bundle; equals (Count != DEPTH).
- Instr_IN  input  DATA_W  fetched instruction.
- Instr_PC_IN  input  DATA_W  address of fetched instruction.
- Instr_PC_Plus4_IN  input  DATA_W  address of following instruction.
- Branch_prediction_IN  input  1  predicted-taken bit from fetch.
- STALL  input  1  decode cannot consume this cycle.
- Deq_Valid  output  1  head entry valid; equals (Count != 0).
- Instr_OUT  output  DATA_W  head instruction; 0 when Deq_Valid=0.
- Instr_PC_OUT  output  DATA_W  head PC; 0 when Deq_Valid=0.
- Instr_PC_Plus4_OUT  output  DATA_W  head PC+4; 0 when Deq_Valid=0.
- Branch_prediction_OUT  output  1  head prediction bit; 0 when Deq_Valid=0.
- Count  output  PTR_W+1  current occupancy, 0..DEPTH.

Behaviour:
- Circular buffer of DEPTH entries; write pointer, read pointer (PTR_W bits, wrap modulo DEPTH) and Count register (PTR_W+1 bits).
- Reset (RESET=1, asynchronous): pointers=0, Count=0, all entry storage=0; therefore Enq_Ready=1, Deq_Valid=0, all data outputs 0.
- Enqueue fires when Enq_Valid && Enq_Ready at a rising edge: entry[wptr] <= inputs, wptr <= wptr+1.
- Dequeue fires when Deq_Valid && !STALL at a rising edge: rptr <= rptr+1.
- Count: +1 on enqueue only, -1 on dequeue only, unchanged on both or neither.
- Latency: a bundle enqueued into an empty queue at edge N appears on the outputs with Deq_Valid=1 after edge N; no same-cycle bypass.
- Ordering is strict FIFO; no entry is ever duplicated or skipped.
- Full: Enq_Ready=0; Enq_Valid is ignored and the data is not written. Enq_Ready is derived from Count only, so a dequeue in the same cycle does not open a slot until the next cycle.
- Empty: Deq_Valid=0 and STALL is ignored; outputs are forced to 0, giving a bubble to decode.
- Simultaneous enqueue and dequeue at non-empty, non-full occupancy: both occur and Count is unchanged.
- FLUSH=1 at an edge takes priority over enqueue and dequeue:
  - pointers=0, Count=0;
  - any enqueue attempted that cycle is dropped;
  - entry storage need not be cleared, because outputs are masked by Deq_Valid.
- FLUSH while STALL=1 still empties the queue.
- RESET asserted mid-operation discards all contents immediately, without waiting for a clock edge.
- Outputs are combinational from the head entry and Count (masked by Deq_Valid); there is no combinational path from Enq_* to Deq_* or from STALL to Enq_Ready.

Optional Feature:
- Macro: FETCHQ_STALL_STATS_EN.
- Defined:
  - adds output Full_Stall_Cycles (32 bits), reset to 0 and cleared by FLUSH;
  - increments by 1 on each rising edge where Enq_Valid=1 and Enq_Ready=0;
  - saturates at 32'hFFFFFFFF.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset then single enqueue: RESET pulse, then Enq_Valid=1, Instr_IN=0x8C010004, Instr_PC_IN=0x00400000, Instr_PC_Plus4_IN=0x00400004, Branch_prediction_IN=1 for 1 cycle -> after that edge Deq_Valid=1, outputs match inputs, Count=1; STALL=0 for 1 edge -> Count=0, outputs=0.
- Fill under STALL=1 (DEPTH=4): 5 consecutive enqueues with PCs 0x100,0x104,0x108,0x10C,0x110 -> Count=4, Enq_Ready=0 after the 4th edge; PC 0x110 is not stored; release STALL -> outputs present PCs 0x100..0x10C in order, then Deq_Valid=0.
- Full plus dequeue same cycle: Count=4, STALL=0, Enq_Valid=1 -> Count=3, Enq_Ready=1 next cycle, the new bundle is not written in that cycle.
- Streaming: continuous enqueue and dequeue from Count=1 for 10 cycles -> Count stays 1 and output PCs advance by 4 each cycle, with no wrap-around corruption after the pointers wrap twice.
- Flush priority: Count=3, FLUSH=1, Enq_Valid=1, STALL=0 -> Count=0, Deq_Valid=0, outputs 0; with FETCHQ_STALL_STATS_EN, Full_Stall_Cycles=0.
- Asynchronous reset mid-stream: RESET asserted between edges with Count=2 -> Count=0, Deq_Valid=0, Enq_Ready=1 immediately, before the next CLK edge.
